// File: rtl/pattern_pkg.sv
// Shared types and the "01" detector next-state function used by the
// pattern-detect scheduler.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT0  = 2'd1,
        MATCH = 2'd2
    } det_state_t;

    // One step of the "01" detector; any unused encoding recovers to IDLE.
    function automatic det_state_t det_next(input det_state_t s, input logic a);
        det_state_t n;
        n = IDLE;
        case (s)
            IDLE:    n = a ? IDLE  : GOT0;
            GOT0:    n = a ? MATCH : GOT0;
            MATCH:   n = a ? IDLE  : GOT0;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: combinational one-hot grant searched from a
// rotating pointer, pointer advances past the winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        ptr_nxt = ptr;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Time-shares one "01" detector step among N serial channels, with per-channel
// state, registered match pulses and saturating match counters.
module pattern_detect_scheduler
    import pattern_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         bit_in,
    input  logic [N-1:0]         flush,
    input  logic                 clear_cnt,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         match,
    input  logic [$clog2(N)-1:0] cnt_sel,
    output logic [CNT_W-1:0]     cnt_data
);

    localparam int unsigned SW = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     eligible;
    det_state_t       st     [N];
    det_state_t       st_nxt [N];
    logic [N-1:0]     hit;
    logic [CNT_W-1:0] cnt    [N];
    logic [CNT_W-1:0] cnt_rd [2**SW];

    // Flushed channels sit out arbitration so their bit is not consumed.
    assign eligible = req & ~flush;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (eligible),
        .gnt   (gnt)
    );

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            st_nxt[i] = det_next(st[i], bit_in[i]);
            hit[i]    = gnt[i] && (st_nxt[i] == MATCH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                st[i] <= IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (flush[i]) begin
                    st[i] <= IDLE;
                end else if (gnt[i]) begin
                    st[i] <= st_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match <= '0;
        end else begin
            match <= hit;
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (clear_cnt) begin
                    cnt[i] <= '0;
                end else if (hit[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Readback table padded to a power of two so every cnt_sel value is defined.
    for (genvar g = 0; g < 2**SW; g++) begin : g_rd
        if (g < N) begin : g_used
            assign cnt_rd[g] = cnt[g];
        end else begin : g_pad
            assign cnt_rd[g] = '0;
        end
    end

    assign cnt_data = cnt_rd[cnt_sel];

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
// Self-checking bench for pattern_detect_scheduler: directed scenarios plus a
// randomized run against a bit-history reference model.
`timescale 1ns/1ps
module tb_pattern_detect_scheduler;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SW    = 2;
    localparam int          CMAX  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, bit_in, flush, gnt, match;
    logic             clear_cnt;
    logic [SW-1:0]    cnt_sel;
    logic [CNT_W-1:0] cnt_data;

    always #5 clk = ~clk;

    pattern_detect_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .flush     (flush),
        .clear_cnt (clear_cnt),
        .gnt       (gnt),
        .match     (match),
        .cnt_sel   (cnt_sel),
        .cnt_data  (cnt_data)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: a "01" match is a consumed 1 whose previously consumed
    // bit (since reset/flush) was 0.
    int           mptr;
    bit           pv [N];
    bit           pb [N];
    int           mcnt [N];
    logic [N-1:0] exp_gnt, obs_gnt, exp_match, obs_match;
    logic [CNT_W-1:0] obs_cnt;

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input logic [N-1:0] f);
        logic [N-1:0] g;
        bit done;
        int idx;
        g = '0;
        done = 0;
        for (int i = 0; i < N; i++) begin
            idx = (mptr + i) % N;
            if (!done && r[idx] && !f[idx]) begin
                g[idx] = 1'b1;
                done = 1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        mptr = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 0; pb[i] = 0; mcnt[i] = 0;
        end
    endtask

    // Entered and left at posedge+1; captures gnt mid-cycle, match/cnt after the edge.
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] b,
                               input logic [N-1:0] f, input logic c);
        req = r; bit_in = b; flush = f; clear_cnt = c;
        exp_gnt = model_grant(r, f);
        @(negedge clk);
        obs_gnt = gnt;
        @(posedge clk);
        exp_match = '0;
        for (int k = 0; k < N; k++) begin
            if (exp_gnt[k]) begin
                exp_match[k] = pv[k] && !pb[k] && b[k];
                pv[k] = 1;
                pb[k] = b[k];
                mptr = (k + 1) % N;
            end
            if (f[k]) pv[k] = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (c) mcnt[k] = 0;
            else if (exp_match[k] && mcnt[k] < CMAX) mcnt[k]++;
        end
        #1;
        obs_match = match;
        obs_cnt   = cnt_data;
    endtask

    task automatic rst_pulse();
        reset = 1'b1; req = '0; bit_in = '0; flush = '0; clear_cnt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        cnt_sel = '0;
        rst_pulse();
        total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt);
        else passed++;
        total++;
        if (match !== 4'b0000) $display("FAIL reset_match: got %b expected 0000", match);
        else passed++;
        for (int i = 0; i < N; i++) begin
            cnt_sel = SW'(i);
            #1;
            total++;
            if (cnt_data !== 2'd0) $display("FAIL reset_cnt%0d: got %0d expected 0", i, cnt_data);
            else passed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        rst_pulse();
        drive_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
        total++;
        if (obs_gnt !== 4'b0001 || obs_match !== 4'b0000)
            $display("FAIL single_bit0: gnt %b match %b expected 0001 0000", obs_gnt, obs_match);
        else passed++;
        drive_cycle(4'b0001, 4'b0001, 4'b0000, 1'b0);
        total++;
        if (obs_gnt !== 4'b0001 || obs_match !== 4'b0001)
            $display("FAIL single_bit1: gnt %b match %b expected 0001 0001", obs_gnt, obs_match);
        else passed++;
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
        total++;
        if (obs_match !== 4'b0000 || obs_gnt !== 4'b0000)
            $display("FAIL single_pulse_width: gnt %b match %b expected 0000 0000", obs_gnt, obs_match);
        else passed++;
        cnt_sel = 2'd0;
        #1;
        total++;
        if (cnt_data !== 2'd1) $display("FAIL single_cnt: got %0d expected 1", cnt_data);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        rst_pulse();
        for (int c = 0; c < 5; c++) begin
            want = 4'b0001 << (c % 4);
            drive_cycle(4'b1111, 4'b1111, 4'b0000, 1'b0);
            total++;
            if (obs_gnt !== want || obs_match !== 4'b0000)
                $display("FAIL rr_cycle%0d: gnt %b match %b expected %b 0000", c, obs_gnt, obs_match, want);
            else passed++;
        end
    endtask

    task automatic test_interleaved();
        logic [N-1:0] r_seq [4] = '{4'b0010, 4'b0100, 4'b0100, 4'b0010};
        logic [N-1:0] b_seq [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0010};
        logic [N-1:0] m_seq [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
        logic [CNT_W-1:0] c_exp [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
        rst_pulse();
        for (int s = 0; s < 4; s++) begin
            drive_cycle(r_seq[s], b_seq[s], 4'b0000, 1'b0);
            total++;
            if (obs_gnt !== r_seq[s] || obs_match !== m_seq[s])
                $display("FAIL interleave_step%0d: gnt %b match %b expected %b %b",
                         s, obs_gnt, obs_match, r_seq[s], m_seq[s]);
            else passed++;
        end
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < N; i++) begin
            cnt_sel = SW'(i);
            #1;
            total++;
            if (cnt_data !== c_exp[i]) $display("FAIL interleave_cnt%0d: got %0d expected %0d", i, cnt_data, c_exp[i]);
            else passed++;
        end
        @(posedge clk);
        #1;
        // ch2 was left in GOT0, so a lone "1" completes a match.
        drive_cycle(4'b0100, 4'b0100, 4'b0000, 1'b0);
        total++;
        if (obs_match !== 4'b0100) $display("FAIL interleave_ch2_got0: match %b expected 0100", obs_match);
        else passed++;
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        rst_pulse();
        cnt_sel = 2'd3;
        for (int s = 0; s < 5; s++) begin
            drive_cycle(4'b1000, 4'b0000, 4'b0000, 1'b0);
            drive_cycle(4'b1000, 4'b1000, 4'b0000, 1'b0);
            if (obs_match === 4'b1000) pulses++;
        end
        total++;
        if (pulses != 5) $display("FAIL sat_pulses: got %0d expected 5", pulses);
        else passed++;
        total++;
        if (cnt_data !== 2'd3) $display("FAIL sat_cnt: got %0d expected 3", cnt_data);
        else passed++;
    endtask

    task automatic test_clear_flush();
        rst_pulse();
        cnt_sel = 2'd0;
        drive_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0001, 4'b0001, 4'b0000, 1'b1);
        total++;
        if (obs_match !== 4'b0001 || obs_cnt !== 2'd0)
            $display("FAIL clear_vs_inc: match %b cnt %0d expected 0001 0", obs_match, obs_cnt);
        else passed++;
        drive_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0011, 4'b0001, 4'b0001, 1'b0);
        total++;
        if (obs_gnt !== 4'b0010) $display("FAIL flush_gnt: gnt %b expected 0010", obs_gnt);
        else passed++;
        drive_cycle(4'b0001, 4'b0001, 4'b0000, 1'b0);
        total++;
        if (obs_gnt !== 4'b0001 || obs_match !== 4'b0000)
            $display("FAIL flush_no_match: gnt %b match %b expected 0001 0000", obs_gnt, obs_match);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rst_pulse();
        drive_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0010, 4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        total++;
        if (obs_match !== 4'b0010) $display("FAIL mid_pre_match: match %b expected 0010", obs_match);
        else passed++;
        req = '0; flush = '0; clear_cnt = 1'b0;
        reset = 1'b1;
        cnt_sel = 2'd1;
        #2;
        total++;
        if (match !== 4'b0000 || gnt !== 4'b0000 || cnt_data !== 2'd0)
            $display("FAIL mid_async_clear: match %b gnt %b cnt1 %0d expected 0000 0000 0", match, gnt, cnt_data);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive_cycle(4'b1111, 4'b1111, 4'b0000, 1'b0);
        total++;
        if (obs_gnt !== 4'b0001 || obs_match !== 4'b0000)
            $display("FAIL mid_first_one: gnt %b match %b expected 0001 0000", obs_gnt, obs_match);
        else passed++;
        drive_cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
        drive_cycle(4'b0001, 4'b0001, 4'b0000, 1'b0);
        total++;
        if (obs_match !== 4'b0001) $display("FAIL mid_rematch: match %b expected 0001", obs_match);
        else passed++;
    endtask

    task automatic test_random();
        bit           pend [N];
        bit           pbit [N];
        logic [N-1:0] r, b, f;
        logic         c;
        int           sel;
        rst_pulse();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; pbit[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1;
                    pbit[i] = $urandom_range(1, 0) == 1;
                end
                r[i] = pend[i];
                b[i] = pend[i] ? pbit[i] : ($urandom_range(1, 0) == 1);
                f[i] = ($urandom_range(15, 0) == 0);
            end
            c = ($urandom_range(31, 0) == 0);
            sel = $urandom_range(N - 1, 0);
            cnt_sel = SW'(sel);
            drive_cycle(r, b, f, c);
            total++;
            if (obs_gnt !== exp_gnt) $display("FAIL rand_gnt cyc %0d: got %b expected %b", cyc, obs_gnt, exp_gnt);
            else passed++;
            total++;
            if (obs_match !== exp_match) $display("FAIL rand_match cyc %0d: got %b expected %b", cyc, obs_match, exp_match);
            else passed++;
            total++;
            if (int'(obs_cnt) != mcnt[sel]) $display("FAIL rand_cnt%0d cyc %0d: got %0d expected %0d", sel, cyc, obs_cnt, mcnt[sel]);
            else passed++;
            for (int i = 0; i < N; i++) if (exp_gnt[i]) pend[i] = 0;
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; bit_in = '0; flush = '0; clear_cnt = 1'b0; cnt_sel = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_interleaved();
        test_saturation();
        test_clear_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
